// File: rtl/fp32_stream_sum.sv
// rtl/fp32_stream_sum.sv - fp32 stream reducer hiding a 10-cycle adder latency with interleaved partial sums
module fp32_add #(
    parameter int LATENCY = 10
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        valid_out,
    output logic [31:0] c_out
);
    logic [31:0] x, y, res;
    logic [7:0]  x_ex, y_ex, d;
    logic [23:0] x_m, y_m;
    logic [50:0] bx;
    logic [26:0] xa, ya, n;
    logic [27:0] s;
    logic [4:0]  lz, sh;
    logic [9:0]  e;
    logic [24:0] mr;
    logic        rup;

    // Round-to-nearest-even add; subnormal inputs use exponent 1 without a hidden bit.
    always_comb begin
        x    = (a_in[30:0] >= b_in[30:0]) ? a_in : b_in;
        y    = (a_in[30:0] >= b_in[30:0]) ? b_in : a_in;
        x_m  = {x[30:23] != 8'd0, x[22:0]};
        y_m  = {y[30:23] != 8'd0, y[22:0]};
        x_ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        y_ex = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        d    = x_ex - y_ex;
        bx   = {y_m, 27'b0} >> ((d > 8'd31) ? 5'd31 : d[4:0]);
        ya   = {bx[50:25], |bx[24:0]};
        xa   = {x_m, 3'b000};
        s    = (x[31] == y[31]) ? ({1'b0, xa} + {1'b0, ya}) : ({1'b0, xa} - {1'b0, ya});
        lz   = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (s[i]) lz = 5'(26 - i);
        end
        sh = 5'd0;
        if (s[27]) begin
            n = {s[27:2], s[1] | s[0]};
            e = {2'b00, x_ex} + 10'd1;
        end else begin
            sh = ({5'd0, lz} < {2'b00, x_ex}) ? lz : 5'(x_ex - 8'd1);
            n  = s[26:0] << sh;
            e  = n[26] ? ({2'b00, x_ex} - {5'd0, sh}) : 10'd0;
        end
        rup = n[2] & (n[1] | n[0] | n[3]);
        mr  = {1'b0, n[26:3]} + {24'd0, rup};
        if (mr[24]) begin
            e  = e + 10'd1;
            mr = mr >> 1;
        end else if (e == 10'd0 && mr[23]) begin
            e = 10'd1;
        end
        if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
            if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) || (y[30:23] == 8'hFF && y[22:0] != 23'd0) ||
                (x[30:23] == 8'hFF && y[30:23] == 8'hFF && x[31] != y[31]))
                res = 32'h7FC00000;
            else
                res = {x[31], 8'hFF, 23'd0};
        end else if (s == 28'd0) begin
            res = {x[31] & y[31], 31'd0};
        end else if (e >= 10'd255) begin
            res = {x[31], 8'hFF, 23'd0};
        end else begin
            res = {x[31], e[7:0], mr[22:0]};
        end
    end

    logic [LATENCY-1:0] v_q;
    logic [31:0]        d_q [LATENCY];

    always_ff @(posedge clk_in) begin
        if (rst_in) v_q <= '0;
        else        v_q <= {v_q[LATENCY-2:0], valid_in};
    end

    always_ff @(posedge clk_in) begin
        d_q[0] <= res;
        for (int i = 1; i < LATENCY; i++) d_q[i] <= d_q[i-1];
    end

    assign valid_out = v_q[LATENCY-1];
    assign c_out     = d_q[LATENCY-1];
endmodule

module fp32_stream_sum #(
    parameter int ADD_LATENCY = 10
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [31:0] data_in,
    input  logic        last_in,
    output logic        ready_in,
    output logic        valid_out,
    output logic [31:0] sum_out
);
    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t      state_q;
    logic        ready_q, valid_out_q, hold_valid_q;
    logic [31:0] sum_q, hold_q;
    logic [3:0]  live_q;
    logic        issue_v, circ_v, accept;
    logic [31:0] issue_a, issue_b, circ;

    assign accept = valid_in && ready_q;

    always_comb begin
        issue_v = 1'b0;
        issue_a = 32'h0;
        issue_b = 32'h0;
        if (state_q == ACCUM) begin
            if (accept) begin
                issue_v = 1'b1;
                issue_a = data_in;
                issue_b = circ_v ? circ : 32'h0;
            end else if (circ_v) begin
                issue_v = 1'b1;
                issue_a = circ;
            end
        end else if (circ_v && live_q != 4'd1 && hold_valid_q) begin
            issue_v = 1'b1;
            issue_a = hold_q;
            issue_b = circ;
        end
    end

    fp32_add #(.LATENCY(ADD_LATENCY)) u_add (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .valid_in (issue_v),
        .a_in     (issue_a),
        .b_in     (issue_b),
        .valid_out(circ_v),
        .c_out    (circ)
    );

    // DRAIN pairs two returning partials via the hold register until one remains.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ACCUM;
            ready_q      <= 1'b1;
            valid_out_q  <= 1'b0;
            sum_q        <= 32'h0;
            hold_q       <= 32'h0;
            hold_valid_q <= 1'b0;
            live_q       <= 4'd0;
        end else begin
            valid_out_q <= 1'b0;
            case (state_q)
                ACCUM: begin
                    if (accept && !circ_v) live_q <= live_q + 4'd1;
                    if (accept && last_in) begin
                        state_q <= DRAIN;
                        ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (circ_v) begin
                        if (live_q == 4'd1) begin
                            valid_out_q  <= 1'b1;
                            sum_q        <= circ;
                            state_q      <= ACCUM;
                            ready_q      <= 1'b1;
                            live_q       <= 4'd0;
                            hold_valid_q <= 1'b0;
                        end else if (!hold_valid_q) begin
                            hold_q       <= circ;
                            hold_valid_q <= 1'b1;
                        end else begin
                            hold_valid_q <= 1'b0;
                            live_q       <= live_q - 4'd1;
                        end
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign ready_in  = ready_q;
    assign valid_out = valid_out_q;
    assign sum_out   = sum_q;
endmodule

// File: tb/tb_fp32_stream_sum.sv
// tb/tb_fp32_stream_sum.sv - directed scoreboard bench for fp32_stream_sum
module tb_fp32_stream_sum;
    logic        clk_in = 1'b0;
    logic        rst_in, valid_in, last_in;
    logic [31:0] data_in;
    logic        ready_in, valid_out;
    logic [31:0] sum_out;

    int          total = 0;
    int          bad = 0;
    int          pulse_cnt = 0;
    int          max_live = 0;
    int          cyc, base;
    logic        ready_ok;
    logic [31:0] exp_q [$];
    logic [31:0] expv;

    fp32_stream_sum dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .valid_in (valid_in),
        .data_in  (data_in),
        .last_in  (last_in),
        .ready_in (ready_in),
        .valid_out(valid_out),
        .sum_out  (sum_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    always @(negedge clk_in) begin
        if (int'(dut.live_q) > max_live) max_live = int'(dut.live_q);
        if (!rst_in && valid_out === 1'b1) begin
            pulse_cnt++;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL spurious_pulse observed=%h expected=no_pulse", sum_out);
            end
            if (exp_q.size() != 0) begin
                expv = exp_q.pop_front();
                check("sum", sum_out, expv);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        while (ready_in !== 1'b1 && n < 200) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (n >= 200) check("ready_wait", {31'd0, ready_in}, 32'd1);
        valid_in = 1'b1;
        data_in  = d;
        last_in  = l;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic wait_pulse(input int budget, output int cycles);
        int start = pulse_cnt;
        cycles = 0;
        while (pulse_cnt == start && cycles < budget) begin
            @(negedge clk_in); #1;
            cycles++;
            if (pulse_cnt == start && ready_in !== 1'b0) ready_ok = 1'b0;
        end
        total++;
        assert (pulse_cnt != start) else begin
            bad++;
            $error("FAIL pulse_timeout observed=none expected=pulse within %0d", budget);
        end
        @(posedge clk_in); #1;
    endtask

    initial begin
        rst_in = 1'b1; valid_in = 1'b0; data_in = 32'h0; last_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_ready", {31'd0, ready_in}, 32'd1);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_sum", sum_out, 32'h0);
        rst_in = 1'b0;

        // single element: latency 11
        exp_q.push_back(32'h3F800000);
        send(32'h3F800000, 1'b1);
        wait_pulse(100, cyc);
        check("t1_latency", cyc, 32'd11);

        exp_q.push_back(32'h41200000);
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b0);
        send(32'h40800000, 1'b1);
        wait_pulse(200, cyc);

        // 20 x 1.0 back-to-back
        exp_q.push_back(32'h41A00000);
        for (int i = 0; i < 19; i++) send(32'h3F800000, 1'b0);
        base = pulse_cnt;
        ready_ok = 1'b1;
        send(32'h3F800000, 1'b1);
        wait_pulse(300, cyc);
        check("t3_ready_low", {31'd0, ready_ok}, 32'd1);
        repeat (30) @(posedge clk_in);
        #1;
        check("t3_one_pulse", pulse_cnt - base, 32'd1);

        // sparse input: live stays at 3
        max_live = 0;
        exp_q.push_back(32'h40C00000);
        send(32'h40000000, 1'b0);
        repeat (7) @(posedge clk_in);
        #1;
        send(32'h40000000, 1'b0);
        repeat (7) @(posedge clk_in);
        #1;
        send(32'h40000000, 1'b1);
        wait_pulse(200, cyc);
        check("t4_max_live_le3", {31'd0, max_live <= 3}, 32'd1);

        // reset mid-vector
        for (int i = 0; i < 6; i++) send(32'h3F800000, 1'b0);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        check("mid_rst_ready", {31'd0, ready_in}, 32'd1);
        check("mid_rst_valid", {31'd0, valid_out}, 32'd0);
        check("mid_rst_sum", sum_out, 32'h0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        exp_q.push_back(32'h40000000);
        send(32'h3F800000, 1'b0);
        send(32'h3F800000, 1'b1);
        wait_pulse(200, cyc);

        // cancellation followed by an immediate vector
        base = pulse_cnt;
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'h3F800000);
        send(32'h40A00000, 1'b0);
        send(32'hC0A00000, 1'b1);
        send(32'h3F800000, 1'b1);
        wait_pulse(200, cyc);
        check("t6_two_pulses", pulse_cnt - base, 32'd2);

        exp_q.push_back(32'h40700000);
        send(32'h3FC00000, 1'b0);
        send(32'h40100000, 1'b1);
        wait_pulse(200, cyc);

        // half-ulp tie rounds to even
        exp_q.push_back(32'h3F800000);
        send(32'h3F800000, 1'b0);
        send(32'h33800000, 1'b1);
        wait_pulse(200, cyc);

        repeat (20) @(posedge clk_in);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
